commit_trace_buffer: RTL and testbench
======================================

Name: commit_trace_buffer

Overview:
Synthesizable retirement monitor for the single-cycle CPU. It samples the commit-side signals every cycle: PC, register write, memory access and halt. Each retired instruction becomes a typed trace record with an instruction number, stored in a parametrised circular buffer. Records drain through a valid/ready port, and the block keeps cycle/instruction counters, a watchdog timeout and overflow statistics. It sits beside `cpu` at the top level and replaces file-based tracing on FPGA/emulation builds.

Parameters:
- DATA_W, 16, width of PC/data/address fields.
- REG_W, 4, register-index width.
- DEPTH, 16, buffer entries; power of two, >=2.
- CNT_W, 32, width of cycle/instruction/drop counters.
- MAX_CYCLES, 100000, watchdog limit in RUN cycles.
- WRAP, 0. 0 = drop new records when full; 1 = overwrite oldest.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  capture enable.
- commit_valid  in  1  an instruction retires this cycle; tie 1 for single-cycle core.
- pc  in  DATA_W  PC of the retiring instruction.
- reg_write  in  1  register file written.
- write_reg  in  REG_W  destination register.
- write_data  in  DATA_W  register write data.
- mem_read  in  1  load.
- mem_write  in  1  store.
- mem_addr  in  DATA_W  memory address.
- mem_data  in  DATA_W  store data.
- hlt  in  1  halt retiring.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts head.
- out_kind  out  3  record kind.
- out_inum  out  CNT_W  instruction number.
- out_pc  out  DATA_W  PC field.
- out_reg  out  REG_W  register field.
- out_value  out  DATA_W  value field.
- out_addr  out  DATA_W  address field.
- state  out  2  monitor state.
- cycle_count  out  CNT_W  cycles spent in RUN.
- inst_count  out  CNT_W  retired instructions.
- drop_count  out  CNT_W  records lost (stop mode) or overwritten (wrap mode).
- overflow  out  1  sticky; set on first drop or overwrite.
- level  out  clog2(DEPTH)+1  buffer occupancy.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all counters, pointers and level=0; out_valid=0, overflow=0. All out_* fields read 0 while empty.
- States: IDLE=0, RUN=1, HALTED=2, TIMEOUT=3.
  - IDLE->RUN when en=1.
  - RUN->IDLE when en=0; counters hold.
  - RUN->HALTED on capture of a commit with hlt=1.
  - RUN->TIMEOUT when cycle_count reaches MAX_CYCLES.
  - If halt and timeout occur in the same cycle, HALTED wins.
  - HALTED and TIMEOUT are left only by reset.
  - Drain continues in every state.
- RUN: cycle_count increments every cycle. When commit_valid=1:
  - inst_count increments.
  - A record is pushed with inum equal to the pre-increment inst_count, so numbering starts at 0.
- Kind priority, matching the trace format:
  - reg_write & mem_read -> LOAD=1: value=write_data, addr=mem_addr, reg=write_reg.
  - reg_write -> REG=0: value=write_data, addr=0.
  - hlt -> HALT=4: value=0, addr=0.
  - mem_write -> STORE=2: value=mem_data, addr=mem_addr, reg=0.
  - otherwise -> NOP=3, all fields 0 except pc and inum.
- Latency: a record captured at edge N is visible with out_valid=1 after edge N when the buffer was empty. Head is first-word-fall-through.
- Pop occurs at an edge where out_valid & out_ready; the head must be stable while out_valid=1 and out_ready=0.
- Full, stop mode (WRAP=0): a push without a simultaneous pop is dropped. drop_count increments, overflow is set, and the HALT state transition still happens.
- Full, wrap mode (WRAP=1): a push without a pop overwrites the oldest entry. The read pointer advances, level stays DEPTH, drop_count increments, overflow is set.
- Full with push and pop together: normal operation, no drop, level unchanged.
- Empty with a pop request: ignored.
- Pointers wrap modulo DEPTH. Counters saturate at all-ones rather than wrapping.
- Reset mid-drain: the buffer is discarded immediately.

Decomposition:
- Package `trace_pkg`:
  - kind encodings.
  - state encodings.
  - record struct {kind, inum, pc, reg, value, addr} and its width function.
- Sub-module `trace_fifo`: parametric DEPTH x record circular buffer with FWFT head, level and a WRAP overwrite input.
- Top-level block: holds the FSM, classification logic and counters.

Test Plan:
- Reset then en=1; retire REG r3=0x0042 at pc 0x0000 -> after one edge: out_valid=1, kind=0, inum=0, reg=3, value=0x0042; inst_count=1.
- Load r5<-[0x0010]=0xBEEF, then store [0x0020]=0x1234 -> records LOAD (addr 0x0010, value 0xBEEF) then STORE (reg 0, value 0x1234); inum 0,1.
- DEPTH=4, WRAP=0, out_ready=0, 6 commits -> level=4; drop_count=2; overflow=1; drained inum 0..3.
- Same stimulus with WRAP=1 -> level=4; drop_count=2; drained inum 2..5.
- hlt at pc 0x001A -> HALT record; state=2; later commits are ignored; drain still works; with a full buffer in stop mode, state=2 and drop_count increments.
- MAX_CYCLES=10, no halt -> state=3 after 10 RUN cycles; cycle_count=10. Then assert rst_n=0 mid-drain -> out_valid=0 and level=0 immediately.

Source files
------------

// File: rtl/commit_trace_buffer_pkg.sv
// Shared encodings for the commit trace monitor: record kinds, monitor states,
// and the packed record width used to size the trace buffer.
package trace_pkg;

  typedef enum logic [2:0] {
    KIND_REG   = 3'd0,
    KIND_LOAD  = 3'd1,
    KIND_STORE = 3'd2,
    KIND_NOP   = 3'd3,
    KIND_HALT  = 3'd4
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam int KIND_W = 3;

  // Record layout is {kind, inum, pc, reg, value, addr}. The struct itself
  // lives in the top, where the field widths are known.
  function automatic int recWidth(input int cntW, input int dataW, input int regW);
    return KIND_W + cntW + 3 * dataW + regW;
  endfunction

endpackage

// File: rtl/commit_trace_buffer_fifo.sv
// Circular record buffer with a first-word-fall-through head, an occupancy level
// and an optional overwrite-oldest policy when a push finds the buffer full.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wrap,
  input  logic                   push,
  input  logic [W-1:0]           pushData,
  input  logic                   pop,
  output logic [W-1:0]           headData,
  output logic                   notEmpty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   dropped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [LVL_W-1:0] levelQ;
  logic             full;
  logic             doPop;
  logic             doWrite;
  logic             overflowPush;
  logic             advRd;

  assign full     = (levelQ == LVL_W'(DEPTH));
  assign notEmpty = (levelQ != '0);
  assign level    = levelQ;

  // A pop on an empty buffer is ignored; a simultaneous pop frees the slot a
  // full-buffer push needs, so that case never counts as a drop.
  assign doPop        = pop && notEmpty;
  assign overflowPush = push && full && !doPop;
  assign doWrite      = push && (!full || doPop || wrap);
  assign advRd        = doPop || (overflowPush && wrap);
  assign dropped      = overflowPush;

  assign headData = notEmpty ? mem[rdPtr] : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr  <= '0;
      wrPtr  <= '0;
      levelQ <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + PTR_W'(1);
      if (advRd)   rdPtr <= rdPtr + PTR_W'(1);
      if (doWrite && !doPop && !full) levelQ <= levelQ + LVL_W'(1);
      else if (doPop && !doWrite)     levelQ <= levelQ - LVL_W'(1);
    end
  end

  // NOTE: storage is deliberately not reset; level and pointers define which
  // entries are live, and the head is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement monitor: classifies each committed instruction into a trace record,
// buffers it for a valid/ready drain port and keeps run/timeout statistics.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_W      = 4,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 100000,
  parameter int WRAP       = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   commit_valid,
  input  logic [DATA_W-1:0]      pc,
  input  logic                   reg_write,
  input  logic [REG_W-1:0]       write_reg,
  input  logic [DATA_W-1:0]      write_data,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [DATA_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_data,
  input  logic                   hlt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             out_kind,
  output logic [CNT_W-1:0]       out_inum,
  output logic [DATA_W-1:0]      out_pc,
  output logic [REG_W-1:0]       out_reg,
  output logic [DATA_W-1:0]      out_value,
  output logic [DATA_W-1:0]      out_addr,
  output logic [1:0]             state,
  output logic [CNT_W-1:0]       cycle_count,
  output logic [CNT_W-1:0]       inst_count,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  typedef struct packed {
    kind_e             kind;
    logic [CNT_W-1:0]  inum;
    logic [DATA_W-1:0] pc;
    logic [REG_W-1:0]  regIdx;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] addr;
  } rec_t;

  localparam int REC_W = recWidth(CNT_W, DATA_W, REG_W);

  state_e           stateQ, stateD;
  logic [CNT_W-1:0] cycleQ, instQ, dropQ;
  logic [CNT_W-1:0] cycleInc;
  logic             ovfQ;
  logic             active;
  logic             capture;
  logic             timeoutHit;
  logic             dropped;
  rec_t             newRec;
  rec_t             headRec;
  logic [REC_W-1:0] headBits;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The enabling cycle in IDLE already counts as a run cycle, so the first
  // commit presented together with en=1 is captured on that same edge.
  assign active     = en && (stateQ == ST_IDLE || stateQ == ST_RUN);
  assign capture    = active && commit_valid;
  assign cycleInc   = satInc(cycleQ);
  assign timeoutHit = active && (cycleInc >= CNT_W'(MAX_CYCLES));

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      ST_IDLE, ST_RUN: begin
        if (!en)                  stateD = ST_IDLE;
        else if (capture && hlt)  stateD = ST_HALTED;
        else if (timeoutHit)      stateD = ST_TIMEOUT;
        else                      stateD = ST_RUN;
      end
      default: stateD = stateQ;
    endcase
  end

  // Classification priority mirrors the file-based trace format.
  always_comb begin
    newRec      = '0;
    newRec.pc   = pc;
    newRec.inum = instQ;
    if (reg_write && mem_read) begin
      newRec.kind   = KIND_LOAD;
      newRec.regIdx = write_reg;
      newRec.value  = write_data;
      newRec.addr   = mem_addr;
    end else if (reg_write) begin
      newRec.kind   = KIND_REG;
      newRec.regIdx = write_reg;
      newRec.value  = write_data;
    end else if (hlt) begin
      newRec.kind   = KIND_HALT;
    end else if (mem_write) begin
      newRec.kind   = KIND_STORE;
      newRec.value  = mem_data;
      newRec.addr   = mem_addr;
    end else begin
      newRec.kind   = KIND_NOP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= ST_IDLE;
      cycleQ <= '0;
      instQ  <= '0;
      dropQ  <= '0;
      ovfQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (active)  cycleQ <= cycleInc;
      if (capture) instQ  <= satInc(instQ);
      if (dropped) begin
        dropQ <= satInc(dropQ);
        ovfQ  <= 1'b1;
      end
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) uFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wrap     (WRAP != 0),
    .push     (capture),
    .pushData (newRec),
    .pop      (out_ready),
    .headData (headBits),
    .notEmpty (out_valid),
    .level    (level),
    .dropped  (dropped)
  );

  assign headRec     = headBits;
  assign out_kind    = headRec.kind;
  assign out_inum    = headRec.inum;
  assign out_pc      = headRec.pc;
  assign out_reg     = headRec.regIdx;
  assign out_value   = headRec.value;
  assign out_addr    = headRec.addr;

  assign state       = stateQ;
  assign cycle_count = cycleQ;
  assign inst_count  = instQ;
  assign drop_count  = dropQ;
  assign overflow    = ovfQ;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: a stop-mode and a wrap-mode instance
// share stimulus, and scoreboard queues hold the records each should drain.
module tb_commit_trace_buffer;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] inum;
    logic [15:0] pc;
    logic [3:0]  regIdx;
    logic [15:0] value;
    logic [15:0] addr;
  } rec_t;

  logic        clk, rst_n, en, commit_valid, reg_write, mem_read, mem_write, hlt, out_ready;
  logic [15:0] pc, write_data, mem_addr, mem_data;
  logic [3:0]  write_reg;

  logic        aValid, bValid, aOvf, bOvf;
  logic [2:0]  aKind, bKind, aLevel, bLevel;
  logic [31:0] aInum, bInum, aCyc, bCyc, aInst, bInst, aDrop, bDrop;
  logic [15:0] aPc, bPc, aValue, bValue, aAddr, bAddr;
  logic [3:0]  aReg, bReg;
  logic [1:0]  aState, bState;

  int   total = 0;
  int   bad   = 0;
  rec_t qA[$];
  rec_t qB[$];
  int   nA, nB;
  bit   capA, capB;

  commit_trace_buffer #(.DEPTH(4), .WRAP(0)) dutA (
    .clk(clk), .rst_n(rst_n), .en(en), .commit_valid(commit_valid), .pc(pc),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .hlt(hlt), .out_valid(aValid), .out_ready(out_ready), .out_kind(aKind),
    .out_inum(aInum), .out_pc(aPc), .out_reg(aReg), .out_value(aValue), .out_addr(aAddr),
    .state(aState), .cycle_count(aCyc), .inst_count(aInst), .drop_count(aDrop),
    .overflow(aOvf), .level(aLevel)
  );

  commit_trace_buffer #(.DEPTH(4), .WRAP(1), .MAX_CYCLES(10)) dutB (
    .clk(clk), .rst_n(rst_n), .en(en), .commit_valid(commit_valid), .pc(pc),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .hlt(hlt), .out_valid(bValid), .out_ready(out_ready), .out_kind(bKind),
    .out_inum(bInum), .out_pc(bPc), .out_reg(bReg), .out_value(bValue), .out_addr(bAddr),
    .state(bState), .cycle_count(bCyc), .inst_count(bInst), .drop_count(bDrop),
    .overflow(bOvf), .level(bLevel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t expRec(input logic rw, mr, mw, h, input logic [15:0] p,
                                  input logic [3:0] wr, input logic [15:0] wd, ma, md,
                                  input int inum);
    rec_t r;
    r      = '0;
    r.pc   = p;
    r.inum = inum;
    if (rw && mr)   begin r.kind = 3'd1; r.regIdx = wr; r.value = wd; r.addr = ma; end
    else if (rw)    begin r.kind = 3'd0; r.regIdx = wr; r.value = wd; end
    else if (h)     r.kind = 3'd4;
    else if (mw)    begin r.kind = 3'd2; r.value = md; r.addr = ma; end
    else            r.kind = 3'd3;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleIn();
    commit_valid = 0; reg_write = 0; mem_read = 0; mem_write = 0; hlt = 0;
    pc = '0; write_reg = '0; write_data = '0; mem_addr = '0; mem_data = '0;
  endtask

  task automatic commit(input logic rw, mr, mw, h, input logic [15:0] p,
                        input logic [3:0] wr, input logic [15:0] wd, ma, md);
    rec_t r;
    commit_valid = 1; reg_write = rw; mem_read = mr; mem_write = mw; hlt = h;
    pc = p; write_reg = wr; write_data = wd; mem_addr = ma; mem_data = md;
    if (capA) begin
      r = expRec(rw, mr, mw, h, p, wr, wd, ma, md, nA);
      nA++;
      if (qA.size() < 4) qA.push_back(r);
      if (h) capA = 0;
    end
    if (capB) begin
      r = expRec(rw, mr, mw, h, p, wr, wd, ma, md, nB);
      nB++;
      if (qB.size() == 4) void'(qB.pop_front());
      qB.push_back(r);
      if (h) capB = 0;
    end
    step();
    idleIn();
  endtask

  task automatic resetAll();
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("rst.aValid", aValid, 0);
    chk("rst.aLevel", aLevel, 0);
    chk("rst.bLevel", bLevel, 0);
    chk("rst.aState", aState, 0);
    chk("rst.aHead", {aKind, aInum, aPc, aReg, aValue, aAddr}, 0);
    chk("rst.aCounters", {aCyc, aInst, aDrop, aOvf}, 0);
    #2;
    rst_n = 1;
    qA.delete(); qB.delete();
    nA = 0; nB = 0; capA = 1; capB = 1;
  endtask

  task automatic drainBoth(input int n);
    for (int i = 0; i < n; i++) begin
      if (qA.size() > 0) begin
        chk("drain.aValid", aValid, 1);
        chk("drain.aHead", {aKind, aInum, aPc, aReg, aValue, aAddr}, qA[0]);
      end
      if (qB.size() > 0) begin
        chk("drain.bValid", bValid, 1);
        chk("drain.bHead", {bKind, bInum, bPc, bReg, bValue, bAddr}, qB[0]);
      end
      out_ready = 1;
      step();
      out_ready = 0;
      if (qA.size() > 0) void'(qA.pop_front());
      if (qB.size() > 0) void'(qB.pop_front());
    end
  endtask

  initial begin
    rst_n = 0; en = 0; out_ready = 0;
    idleIn();
    capA = 1; capB = 1; nA = 0; nB = 0;

    // First REG commit visible one edge after capture
    resetAll();
    en = 1;
    commit(1, 0, 0, 0, 16'h0000, 4'd3, 16'h0042, 16'h0000, 16'h0000);
    chk("t1.aValid", aValid, 1);
    chk("t1.aHead", {aKind, aInum, aPc, aReg, aValue, aAddr}, qA[0]);
    chk("t1.aInst", aInst, 1);
    chk("t1.aState", aState, 1);
    chk("t1.aLevel", aLevel, 1);
    // Head must hold while not accepted
    step();
    chk("t1.aHeadStable", {aKind, aInum, aPc, aReg, aValue, aAddr}, qA[0]);
    drainBoth(1);
    chk("t1.aEmpty", aValid, 0);
    // Pop request on an empty buffer is ignored
    out_ready = 1;
    step();
    out_ready = 0;
    chk("t1.emptyPopLevel", aLevel, 0);
    chk("t1.emptyHeadZero", {aKind, aInum, aPc, aReg, aValue, aAddr}, 0);

    // LOAD then STORE
    resetAll();
    commit(1, 1, 0, 0, 16'h0002, 4'd5, 16'hBEEF, 16'h0010, 16'h0000);
    commit(0, 0, 1, 0, 16'h0004, 4'd7, 16'h0000, 16'h0020, 16'h1234);
    chk("t2.aLevel", aLevel, 2);
    drainBoth(2);

    // Six commits with no drain: stop mode vs wrap mode
    resetAll();
    for (int i = 0; i < 6; i++)
      commit(i[0], 0, 0, 0, 16'(16'h0100 + 2 * i), 4'(i + 1), 16'(16'h00A0 + i), 16'h0000, 16'h0000);
    chk("t3.aLevel", aLevel, 4);
    chk("t3.aDrop", aDrop, 2);
    chk("t3.aOvf", aOvf, 1);
    chk("t3.aInst", aInst, 6);
    chk("t3.bLevel", bLevel, 4);
    chk("t3.bDrop", bDrop, 2);
    chk("t3.bOvf", bOvf, 1);
    chk("t3.bFirstInum", qB[0].inum, 2);
    drainBoth(4);
    chk("t3.aEmpty", aValid, 0);
    chk("t3.bEmpty", bValid, 0);

    // Halt stops capture, drain continues
    resetAll();
    commit(1, 0, 0, 0, 16'h0018, 4'd1, 16'h0011, 16'h0000, 16'h0000);
    commit(0, 0, 0, 1, 16'h001A, 4'd0, 16'h0000, 16'h0000, 16'h0000);
    chk("t4.aState", aState, 2);
    commit(1, 0, 0, 0, 16'h001C, 4'd2, 16'h0022, 16'h0000, 16'h0000);
    chk("t4.aInstHeld", aInst, 2);
    chk("t4.aLevelHeld", aLevel, 2);
    chk("t4.aStateHeld", aState, 2);
    drainBoth(2);

    // Halt arriving on a full stop-mode buffer is dropped but still halts
    resetAll();
    for (int i = 0; i < 4; i++)
      commit(1, 0, 0, 0, 16'(2 * i), 4'(i), 16'(16'h0030 + i), 16'h0000, 16'h0000);
    commit(0, 0, 0, 1, 16'h0008, 4'd0, 16'h0000, 16'h0000, 16'h0000);
    chk("t5.aState", aState, 2);
    chk("t5.aDrop", aDrop, 1);
    chk("t5.aOvf", aOvf, 1);
    chk("t5.aLevel", aLevel, 4);
    chk("t5.bState", bState, 2);
    chk("t5.bDrop", bDrop, 1);
    drainBoth(4);

    // Watchdog on the MAX_CYCLES=10 instance, then reset mid-drain
    resetAll();
    for (int i = 0; i < 3; i++)
      commit(0, 0, 1, 0, 16'(16'h0040 + 2 * i), 4'd0, 16'h0000, 16'(16'h0080 + i), 16'(16'h5500 + i));
    for (int i = 0; i < 6; i++) step();
    chk("t6.bStateRun", bState, 1);
    chk("t6.bCyc9", bCyc, 9);
    step();
    chk("t6.bStateTimeout", bState, 3);
    chk("t6.bCyc10", bCyc, 10);
    chk("t6.aStateRun", aState, 1);
    step();
    chk("t6.bCycHeld", bCyc, 10);
    chk("t6.bInst", bInst, 3);
    drainBoth(1);
    chk("t6.bLevel", bLevel, 2);
    out_ready = 1;
    rst_n = 0;
    #1;
    chk("t6.rstBValid", bValid, 0);
    chk("t6.rstBLevel", bLevel, 0);
    chk("t6.rstAValid", aValid, 0);
    chk("t6.rstBState", bState, 0);
    #2;
    out_ready = 0;
    rst_n = 1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
